// File: rtl/sram_ctrl.sv
// Sequencer between a word-granular load/store port and one asynchronous 32-bit SRAM.
// All chip pins are registered; outputs for the next cycle are decoded from the next state.
module sram_ctrl #(
  parameter int ADDR_W  = 20,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic              we,
  input  logic [31:0]       addr_i,
  input  logic [3:0]        sel_i,
  input  logic [31:0]       data_i,
  output logic [31:0]       data_o,
  output logic              ready_o,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [31:0]       ram_data,
  output logic [3:0]        ram_be_n,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n
);

  localparam int RD_CYC = (RD_WAIT < 1) ? 1 : ((RD_WAIT > 15) ? 15 : RD_WAIT);
  localparam int WR_CYC = (WR_WAIT < 1) ? 1 : ((WR_WAIT > 15) ? 15 : WR_WAIT);
  localparam logic [3:0] RD_LOAD = 4'(RD_CYC - 1);
  localparam logic [3:0] WR_LOAD = 4'(WR_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [3:0]         sel_q, sel_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        data_q, data_d;
  logic               ready_q, ready_d;
  logic               drive_q, drive_d;
  logic               ce_n_q, ce_n_d;
  logic               oe_n_q, oe_n_d;
  logic               we_n_q, we_n_d;
  logic [3:0]         be_n_q, be_n_d;

  logic unused_addr;
  assign unused_addr = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (ce) begin
          if (!we) begin
            addr_d  = addr_i[ADDR_W+1:2];
            cnt_d   = RD_LOAD;
            state_d = RD;
          end else if (sel_i != 4'b0000) begin
            addr_d  = addr_i[ADDR_W+1:2];
            sel_d   = sel_i;
            wdata_d = data_i;
            state_d = WR_SETUP;
          end else begin
            state_d = DONE;
          end
        end
      end
      RD: begin
        if (cnt_q == 4'd0) begin
          data_d  = ram_data;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WR_SETUP: begin
        cnt_d   = WR_LOAD;
        state_d = WR_PULSE;
      end
      WR_PULSE: begin
        if (cnt_q == 4'd0) begin
          state_d = WR_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WR_HOLD: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Pin values for the coming cycle follow directly from the state being entered.
    drive_d = (state_d == WR_SETUP) || (state_d == WR_PULSE) || (state_d == WR_HOLD);
    ce_n_d  = !(drive_d || (state_d == RD));
    oe_n_d  = (state_d != RD);
    we_n_d  = (state_d != WR_PULSE);
    ready_d = (state_d == DONE);
    if (state_d == RD) begin
      be_n_d = 4'b0000;
    end else if (drive_d) begin
      be_n_d = ~sel_d;
    end else begin
      be_n_d = 4'b1111;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      sel_q   <= 4'b0000;
      wdata_q <= 32'd0;
      data_q  <= 32'd0;
      ready_q <= 1'b0;
      drive_q <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      be_n_q  <= 4'b1111;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      drive_q <= drive_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      be_n_q  <= be_n_d;
    end
  end

  assign ram_data = drive_q ? wdata_q : 32'bz;
  assign data_o   = data_q;
  assign ready_o  = ready_q;
  assign ram_addr = addr_q;
  assign ram_be_n = be_n_q;
  assign ram_ce_n = ce_n_q;
  assign ram_oe_n = oe_n_q;
  assign ram_we_n = we_n_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: a small SRAM chip model, a transaction-level
// pin-schedule model compared every cycle, and directed vectors with literal expectations.
module tb_sram_ctrl;

  localparam int ADDR_W  = 20;
  localparam int RD_WAIT = 2;
  localparam int WR_WAIT = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ce;
  logic              we;
  logic [31:0]       addr_i;
  logic [3:0]        sel_i;
  logic [31:0]       data_i;
  logic [31:0]       data_o;
  logic              ready_o;
  logic [ADDR_W-1:0] ram_addr;
  wire  [31:0]       ram_data;
  logic [3:0]        ram_be_n;
  logic              ram_ce_n;
  logic              ram_oe_n;
  logic              ram_we_n;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  logic [31:0] chip      [0:255];
  logic [31:0] model_mem [0:255];

  typedef struct {
    logic              ce_n;
    logic              oe_n;
    logic              we_n;
    logic [3:0]        be_n;
    logic [ADDR_W-1:0] addr;
    logic              drv;
    logic [31:0]       wd;
    logic              rdy;
    logic [31:0]       dout;
  } vec_t;

  vec_t              exp_q[$];
  logic [ADDR_W-1:0] exp_addr;
  logic [31:0]       exp_dout;

  int          we_low_cnt;
  int          ce_low_cnt;
  logic [3:0]  last_be_wr;
  logic [ADDR_W-1:0] last_addr_wr;

  always #5 clk = ~clk;

  sram_ctrl #(.ADDR_W(ADDR_W), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .we(we), .addr_i(addr_i), .sel_i(sel_i),
    .data_i(data_i), .data_o(data_o), .ready_o(ready_o), .ram_addr(ram_addr),
    .ram_data(ram_data), .ram_be_n(ram_be_n), .ram_ce_n(ram_ce_n),
    .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
  );

  // Asynchronous SRAM: drives the bus while selected and output-enabled.
  assign ram_data = (!ram_ce_n && !ram_oe_n) ? chip[ram_addr[7:0]] : 32'bz;

  initial begin
    for (int i = 0; i < 256; i++) begin
      chip[i]      = 32'd0;
      model_mem[i] = 32'd0;
    end
    forever begin
      @(posedge clk);
      if (!ram_ce_n && !ram_we_n) begin
        for (int b = 0; b < 4; b++) begin
          if (!ram_be_n[b]) chip[ram_addr[7:0]][b*8 +: 8] = ram_data[b*8 +: 8];
        end
      end
    end
  end

  function automatic vec_t idleVec(input logic rdy);
    vec_t v;
    v.ce_n = 1'b1; v.oe_n = 1'b1; v.we_n = 1'b1; v.be_n = 4'b1111;
    v.addr = exp_addr; v.drv = 1'b0; v.wd = 32'd0; v.rdy = rdy; v.dout = exp_dout;
    return v;
  endfunction

  // Transaction model: each accepted request expands into its cycle-by-cycle pin schedule,
  // followed by the ready cycle and the mandatory idle cycle.
  initial begin
    logic [ADDR_W-1:0] word;
    vec_t v;
    exp_addr = '0;
    exp_dout = 32'd0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        exp_q.delete();
        exp_addr = '0;
        exp_dout = 32'd0;
        started  = 1'b1;
      end else if (started && exp_q.size() == 0 && ce) begin
        word = addr_i[ADDR_W+1:2];
        if (!we) begin
          exp_addr = word;
          for (int k = 0; k < RD_WAIT; k++) begin
            v = idleVec(1'b0);
            v.ce_n = 1'b0; v.oe_n = 1'b0; v.be_n = 4'b0000;
            exp_q.push_back(v);
          end
          exp_dout = model_mem[word[7:0]];
          exp_q.push_back(idleVec(1'b1));
          exp_q.push_back(idleVec(1'b0));
        end else if (sel_i != 4'b0000) begin
          exp_addr = word;
          for (int b = 0; b < 4; b++) begin
            if (sel_i[b]) model_mem[word[7:0]][b*8 +: 8] = data_i[b*8 +: 8];
          end
          v = idleVec(1'b0);
          v.ce_n = 1'b0; v.be_n = ~sel_i; v.drv = 1'b1; v.wd = data_i;
          exp_q.push_back(v);
          v.we_n = 1'b0;
          for (int k = 0; k < WR_WAIT; k++) exp_q.push_back(v);
          v.we_n = 1'b1;
          exp_q.push_back(v);
          exp_q.push_back(idleVec(1'b1));
          exp_q.push_back(idleVec(1'b0));
        end else begin
          exp_q.push_back(idleVec(1'b1));
          exp_q.push_back(idleVec(1'b0));
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle, DUT pins against the model schedule.
  initial begin
    vec_t e;
    forever begin
      @(negedge clk);
      if (started) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : idleVec(1'b0);
        checkOutput("ram_ce_n", 32'(ram_ce_n), 32'(e.ce_n));
        checkOutput("ram_oe_n", 32'(ram_oe_n), 32'(e.oe_n));
        checkOutput("ram_we_n", 32'(ram_we_n), 32'(e.we_n));
        checkOutput("ram_be_n", 32'(ram_be_n), 32'(e.be_n));
        checkOutput("ram_addr", 32'(ram_addr), 32'(e.addr));
        checkOutput("ready_o",  32'(ready_o),  32'(e.rdy));
        checkOutput("data_o",   data_o,        e.dout);
        if (e.drv) checkOutput("ram_data_wr", ram_data, e.wd);
      end
    end
  end

  initial begin
    we_low_cnt = 0;
    ce_low_cnt = 0;
    last_be_wr = 4'b1111;
    last_addr_wr = '0;
    forever begin
      @(negedge clk);
      if (!ram_we_n) we_low_cnt++;
      if (!ram_ce_n) ce_low_cnt++;
      if (!ram_ce_n && ram_oe_n) begin
        last_be_wr   = ram_be_n;
        last_addr_wr = ram_addr;
      end
    end
  end

  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [3:0] s,
                               input logic [31:0] d, input bit hold_ce, output int lat);
    @(negedge clk);
    ce = 1'b1; we = w; addr_i = a; sel_i = s; data_i = d;
    @(posedge clk);
    lat = 0;
    while (lat < 30) begin
      @(negedge clk);
      lat++;
      if (ready_o) break;
    end
    if (!hold_ce) ce = 1'b0;
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; ce = 1'b1; we = 1'b0; addr_i = 32'd0; sel_i = 4'b1111; data_i = 32'd0;
    repeat (3) @(negedge clk);
    checkOutput("rst_ce_n",  32'(ram_ce_n), 32'd1);
    checkOutput("rst_be_n",  32'(ram_be_n), 32'hF);
    checkOutput("rst_data_o", data_o, 32'd0);
    rst_n = 1'b1; ce = 1'b0;

    we_low_cnt = 0;
    applyStimulus(1'b1, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, 1'b0, lat);
    checkOutput("wr_latency", 32'(lat), 32'd5);
    checkOutput("wr_we_low_cycles", 32'(we_low_cnt), 32'd2);
    checkOutput("wr_addr", 32'(last_addr_wr), 32'h0000_0004);
    applyStimulus(1'b0, 32'h0000_0010, 4'b1111, 32'd0, 1'b0, lat);
    checkOutput("rd_latency", 32'(lat), 32'd3);
    checkOutput("rd_data", data_o, 32'hDEAD_BEEF);

    applyStimulus(1'b1, 32'h0000_0010, 4'b1111, 32'h1122_3344, 1'b0, lat);
    applyStimulus(1'b1, 32'h0000_0012, 4'b0010, 32'h5555_5555, 1'b0, lat);
    checkOutput("lane_be_n", 32'(last_be_wr), 32'hD);
    applyStimulus(1'b0, 32'h0000_0010, 4'b1111, 32'd0, 1'b0, lat);
    checkOutput("lane_rd_data", data_o, 32'h1122_5544);

    ce_low_cnt = 0;
    applyStimulus(1'b1, 32'h0000_0040, 4'b0000, 32'hFFFF_FFFF, 1'b0, lat);
    checkOutput("empty_latency", 32'(lat), 32'd1);
    checkOutput("empty_ce_low_cycles", 32'(ce_low_cnt), 32'd0);
    checkOutput("empty_holds_data_o", data_o, 32'h1122_5544);

    applyStimulus(1'b0, 32'h0000_0010, 4'b1111, 32'd0, 1'b1, lat);
    checkOutput("b2b_rd1", data_o, 32'h1122_5544);
    applyStimulus(1'b1, 32'h0000_0020, 4'b1111, 32'hCAFE_F00D, 1'b1, lat);
    checkOutput("b2b_wr_latency", 32'(lat), 32'd5);
    applyStimulus(1'b0, 32'h0000_0020, 4'b1111, 32'd0, 1'b0, lat);
    checkOutput("b2b_rd2", data_o, 32'hCAFE_F00D);

    // Reset landing on the second write-pulse cycle.
    @(negedge clk);
    ce = 1'b1; we = 1'b1; addr_i = 32'h0000_0030; sel_i = 4'b1111; data_i = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    ce = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("pulse2_we_n", 32'(ram_we_n), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_we_n", 32'(ram_we_n), 32'd1);
    checkOutput("midrst_ce_n", 32'(ram_ce_n), 32'd1);
    checkOutput("midrst_data_o", data_o, 32'd0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h0000_0020, 4'b1111, 32'd0, 1'b0, lat);
    checkOutput("post_rst_latency", 32'(lat), 32'd3);
    checkOutput("post_rst_rd", data_o, 32'hCAFE_F00D);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
